// File: rtl/mul_seq_ctrl.sv
// Sequential unsigned 32x32->64 shift-add multiplier controller.
// Owns the partial-product registers and steers an external 32-bit adder one step per cycle.
module mul_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic [WIDTH-1:0]     add_a,
  output logic [WIDTH-1:0]     add_b,
  output logic                 add_cin,
  input  logic [WIDTH-1:0]     add_sum,
  input  logic                 add_cout
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     m_q, m_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      m_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  // NOTE: every variable gets a hold/default value first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    cnt_d     = cnt_q;
    product_d = product_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          m_d     = multiplicand;
          hi_d    = '0;
          lo_d    = multiplier;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // Shift the 65-bit {cout, sum, LO} right by one; the carry lands in HI's MSB.
        hi_d  = {add_cout, add_sum[WIDTH-1:1]};
        lo_d  = {add_sum[0], lo_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_STEP) begin
          product_d = {add_cout, add_sum, lo_q[WIDTH-1:1]};
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Adder operands come from registers only, keeping start/operand inputs off the adder path.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (state_q == ST_RUN) begin
      add_a = hi_q;
      add_b = lo_q[0] ? m_q : '0;
    end
  end

  assign busy    = (state_q != ST_IDLE);
  assign done    = (state_q == ST_DONE);
  assign product = product_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench for mul_seq_ctrl with a behavioural model of the external adder.
module tb_mul_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic        busy;
  logic        done;
  logic [63:0] product;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic        add_cin;
  logic [31:0] add_sum;
  logic        add_cout;
  logic [32:0] sum33;

  int tests_run;
  int tests_failed;

  mul_seq_ctrl #(.WIDTH(32), .CNT_W(5)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product),
    .add_a        (add_a),
    .add_b        (add_b),
    .add_cin      (add_cin),
    .add_sum      (add_sum),
    .add_cout     (add_cout)
  );

  assign sum33    = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};
  assign add_sum  = sum33[31:0];
  assign add_cout = sum33[32];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Start an operation at the next negedge, then watch busy/done timing and the result.
  task automatic run_op(input logic [31:0] m, input logic [31:0] q,
                        input logic [63:0] exp, input string name,
                        output bit saw_cout);
    int cyc;
    saw_cout = 1'b0;
    @(negedge clk);
    start = 1'b1; multiplicand = m; multiplier = q;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; multiplicand = $urandom; multiplier = $urandom;
    cyc = 1;
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++; $display("FAIL %s busy_c1 got %b want 1", name, busy);
    end
    while (done !== 1'b1 && cyc < 40) begin
      if (add_cout === 1'b1) saw_cout = 1'b1;
      @(negedge clk);
      cyc++;
    end
    tests_run++;
    if (cyc !== 33) begin
      tests_failed++; $display("FAIL %s latency got %0d want 33", name, cyc);
    end
    tests_run++;
    if (product !== exp) begin
      tests_failed++; $display("FAIL %s product got %h want %h", name, product, exp);
    end
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++; $display("FAIL %s busy_done got %b want 1", name, busy);
    end
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      tests_failed++; $display("FAIL %s idle_c34 got busy=%b done=%b want 0 0", name, busy, done);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; multiplicand = '0; multiplier = '0;
    #12;
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 64'd0 ||
        add_a !== 32'd0 || add_b !== 32'd0 || add_cin !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state got busy=%b done=%b product=%h add_a=%h add_b=%h cin=%b want all 0",
               busy, done, product, add_a, add_b, add_cin);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    bit saw;
    run_op(32'h3, 32'h5, 64'h0000_0000_0000_000F, "basic_3x5", saw);
  endtask

  task automatic test_carry_chain();
    bit saw;
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "carry_ff", saw);
    tests_run++;
    if (saw !== 1'b1) begin
      tests_failed++; $display("FAIL carry_cout_seen got %b want 1", saw);
    end
  endtask

  task automatic test_zero_and_one();
    bit saw;
    run_op(32'h0, 32'h1234_5678, 64'd0, "zero_m", saw);
    run_op(32'h89AB_CDEF, 32'h1, 64'h0000_0000_89AB_CDEF, "q_one", saw);
  endtask

  task automatic test_handshake();
    int cyc;
    @(negedge clk);
    start = 1'b1; multiplicand = 32'd7; multiplier = 32'd6;
    @(posedge clk);
    @(negedge clk);
    cyc = 1;
    while (done !== 1'b1 && cyc < 40) begin
      multiplicand = (cyc == 10) ? 32'd3 : 32'd7;
      multiplier   = (cyc == 10) ? 32'd9 : 32'd6;
      @(negedge clk);
      cyc++;
    end
    multiplicand = 32'd7; multiplier = 32'd6;
    tests_run++;
    if (cyc !== 33) begin
      tests_failed++; $display("FAIL hold_first_latency got %0d want 33", cyc);
    end
    tests_run++;
    if (product !== 64'd42) begin
      tests_failed++; $display("FAIL hold_first_product got %h want 42", product);
    end
    @(negedge clk);
    cyc++;
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++; $display("FAIL hold_idle_c34 got busy=%b want 0", busy);
    end
    @(negedge clk);
    cyc++;
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++; $display("FAIL hold_restart_c35 got busy=%b want 1", busy);
    end
    while (done !== 1'b1 && cyc < 80) begin
      @(negedge clk);
      cyc++;
    end
    tests_run++;
    if (cyc !== 67) begin
      tests_failed++; $display("FAIL hold_second_latency got %0d want 67", cyc);
    end
    tests_run++;
    if (product !== 64'd42) begin
      tests_failed++; $display("FAIL hold_second_product got %h want 42", product);
    end
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    bit saw;
    @(negedge clk);
    start = 1'b1; multiplicand = 32'hFFFF_FFFF; multiplier = 32'hFFFF_FFFF;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    tests_run++;
    if (busy !== 1'b1 || add_b !== 32'hFFFF_FFFF) begin
      tests_failed++; $display("FAIL midrun_pre got busy=%b add_b=%h want 1 ffffffff", busy, add_b);
    end
    #1 rst_n = 1'b0;
    #1;
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 64'd0 ||
        add_a !== 32'd0 || add_b !== 32'd0) begin
      tests_failed++;
      $display("FAIL midrun_reset got busy=%b done=%b product=%h add_a=%h add_b=%h want all 0",
               busy, done, product, add_a, add_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, "post_reset", saw);
  endtask

  task automatic test_output_hold();
    bit saw;
    int bad;
    run_op(32'd1000, 32'd1000, 64'd1000000, "hold_setup", saw);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      tests_run++;
      if (product !== 64'd1000000 || done !== 1'b0 || busy !== 1'b0 ||
          add_a !== 32'd0 || add_b !== 32'd0) begin
        tests_failed++;
        if (bad < 3)
          $display("FAIL output_hold cyc %0d got product=%h done=%b busy=%b add_a=%h add_b=%h want f4240 0 0 0 0",
                   i, product, done, busy, add_a, add_b);
        bad++;
      end
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_basic();
    test_carry_chain();
    test_zero_and_one();
    test_handshake();
    test_reset_mid_run();
    test_output_hold();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
